// File: rtl/horner_pkg.sv
// Shared types and sizing for the Horner frame sequencer.
// Latency: n/a (package).
// Backpressure: n/a (package).
package horner_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int LANES      = 4;
   localparam int TW         = LANES * DATA_WIDTH;
   localparam int N_WGT      = 16;
   localparam int N_MAT      = 3;
   localparam int N_ORIENT   = 3;
   localparam int N_IFACE    = 6;
   localparam int N_LREF     = 2;
   localparam int CNT_W      = 16;

   // Reference vectors that precede the CAL_NUM eval vectors.
   localparam int N_REF  = N_ORIENT + N_IFACE + N_LREF;
   // Beat counter covers the longer of the weight / matrix sections.
   localparam int BEAT_W = $clog2(N_WGT);
   // Vector counter must reach N_REF + CAL_NUM - 1 without wrapping.
   localparam int VEC_W  = CNT_W + 1;

   typedef enum logic [2:0] {
      HDR,
      WGT,
      MAT,
      VEC,
      WAIT_RES
   } state_e;

   typedef enum logic [1:0] {
      CLS_ORIENT = 2'd0,
      CLS_IFACE  = 2'd1,
      CLS_LREF   = 2'd2,
      CLS_EVAL   = 2'd3
   } vec_cls_e;

   // Class of a vector from its position inside the vector section.
   function automatic vec_cls_e cls_of(input logic [VEC_W-1:0] idx);
      if (idx < VEC_W'(N_ORIENT))
         return CLS_ORIENT;
      else if (idx < VEC_W'(N_ORIENT + N_IFACE))
         return CLS_IFACE;
      else if (idx < VEC_W'(N_REF))
         return CLS_LREF;
      else
         return CLS_EVAL;
   endfunction

endpackage

// File: rtl/horner_beat_counter.sv
// Up-counter with synchronous load and terminal-count compare.
// Latency: count updates one cycle after inc/load; tc_o is combinational on the count.
// Backpressure: none; the owner gates inc_i with its own handshake.
module horner_beat_counter #(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         inc_i,
   input  logic [W-1:0] last_i,
   output logic [W-1:0] cnt_o,
   output logic         tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Load wins over increment so a frame abort always restarts from a clean value.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (inc_i)
         cnt_d = cnt_q + W'(1);
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == last_i);

endmodule

// File: rtl/horner_frame_ctrl.sv
// Frame sequencer: splits one AXIS frame into weight/matrix writes and classed vectors, tags results with m_tlast.
// Latency: weight/matrix writes 1 cycle registered; vectors 0 cycles pass-through; m_tlast combinational on res_valid.
// Backpressure: s_tready follows vec_ready in VEC, held low in WAIT_RES; optional stats via HORNER_FRAME_STATS_EN.
module horner_frame_ctrl
   import horner_pkg::*;
(
   input  logic             s00_axis_aclk,
   input  logic             s00_axis_aresetn,
   input  logic [TW-1:0]    s_tdata,
   input  logic             s_tvalid,
   output logic             s_tready,
   input  logic             s_tlast,
   output logic             wgt_we,
   output logic [3:0]       wgt_idx,
   output logic [TW-1:0]    wgt_data,
   output logic             mat_we,
   output logic [1:0]       mat_row,
   output logic [TW-1:0]    mat_data,
   output logic             vec_valid,
   input  logic             vec_ready,
   output logic [TW-1:0]    vec_data,
   output logic [1:0]       vec_cls,
   output logic             vec_last,
   input  logic             res_valid,
   output logic             m_tlast,
   output logic             flush,
   output logic             busy,
   output logic             err_len,
`ifdef HORNER_FRAME_STATS_EN
   output logic [31:0]      frame_cnt,
   output logic [15:0]      err_cnt,
`endif
   output logic [CNT_W-1:0] cal_num
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cal_num_q, cal_num_d;
   logic              err_len_q, err_len_d;
   logic              flush_q, flush_d;
   logic              wgt_we_q, wgt_we_d;
   logic [3:0]        wgt_idx_q, wgt_idx_d;
   logic [TW-1:0]     wgt_data_q, wgt_data_d;
   logic              mat_we_q, mat_we_d;
   logic [1:0]        mat_row_q, mat_row_d;
   logic [TW-1:0]     mat_data_q, mat_data_d;

   logic              beat_clr, beat_inc, beat_tc;
   logic [BEAT_W-1:0] beat_cnt, beat_last;
   logic              vec_clr, vec_inc, vec_tc;
   logic [VEC_W-1:0]  vec_cnt, vec_last_idx;
   logic              res_clr, res_inc, res_tc;
   logic [CNT_W-1:0]  res_cnt;

   logic              in_vec, accept, res_live, res_done, short_frame;

   assign in_vec = (state_q == VEC);

   // Vector section is a straight pass-through; the result phase never takes input.
   assign s_tready = in_vec ? vec_ready : (state_q != WAIT_RES);
   assign accept   = s_tvalid && s_tready;

   assign beat_last    = (state_q == MAT) ? BEAT_W'(N_MAT - 1) : BEAT_W'(N_WGT - 1);
   assign vec_last_idx = VEC_W'(N_REF - 1) + {1'b0, cal_num_q};

   // Results are counted from the first vector onward; early results can finish the frame.
   assign res_live = ((state_q == VEC) || (state_q == WAIT_RES)) && (cal_num_q != '0);
   assign res_done = res_live && (res_cnt == cal_num_q);
   assign res_inc  = res_valid && res_live && !res_done;
   assign m_tlast  = res_inc && res_tc;

   // Any s_tlast before the final vector truncates the frame.
   assign short_frame = accept && s_tlast &&
                        ((state_q == WGT) || (state_q == MAT) || (in_vec && !vec_tc));

   assign vec_valid = in_vec && s_tvalid;
   assign vec_data  = in_vec ? s_tdata : '0;
   assign vec_cls   = in_vec ? cls_of(vec_cnt) : CLS_ORIENT;
   assign vec_last  = in_vec && vec_tc;

   assign wgt_we   = wgt_we_q;
   assign wgt_idx  = wgt_idx_q;
   assign wgt_data = wgt_data_q;
   assign mat_we   = mat_we_q;
   assign mat_row  = mat_row_q;
   assign mat_data = mat_data_q;
   assign flush    = flush_q;
   assign busy     = (state_q != HDR);
   assign err_len  = err_len_q;
   assign cal_num  = cal_num_q;

   horner_beat_counter #(.W(BEAT_W)) u_beat_cnt (
      .clk_i      (s00_axis_aclk),
      .rst_ni     (s00_axis_aresetn),
      .load_i     (beat_clr),
      .load_val_i ({BEAT_W{1'b0}}),
      .inc_i      (beat_inc),
      .last_i     (beat_last),
      .cnt_o      (beat_cnt),
      .tc_o       (beat_tc)
   );

   horner_beat_counter #(.W(VEC_W)) u_vec_cnt (
      .clk_i      (s00_axis_aclk),
      .rst_ni     (s00_axis_aresetn),
      .load_i     (vec_clr),
      .load_val_i ({VEC_W{1'b0}}),
      .inc_i      (vec_inc),
      .last_i     (vec_last_idx),
      .cnt_o      (vec_cnt),
      .tc_o       (vec_tc)
   );

   horner_beat_counter #(.W(CNT_W)) u_res_cnt (
      .clk_i      (s00_axis_aclk),
      .rst_ni     (s00_axis_aresetn),
      .load_i     (res_clr),
      .load_val_i ({CNT_W{1'b0}}),
      .inc_i      (res_inc),
      .last_i     (cal_num_q - CNT_W'(1)),
      .cnt_o      (res_cnt),
      .tc_o       (res_tc)
   );

   // Next state, routed writes and counter control; a short frame overrides everything.
   always_comb begin
      state_d    = state_q;
      cal_num_d  = cal_num_q;
      err_len_d  = err_len_q;
      flush_d    = 1'b0;
      wgt_we_d   = 1'b0;
      wgt_idx_d  = wgt_idx_q;
      wgt_data_d = wgt_data_q;
      mat_we_d   = 1'b0;
      mat_row_d  = mat_row_q;
      mat_data_d = mat_data_q;
      beat_clr   = 1'b0;
      beat_inc   = 1'b0;
      vec_clr    = 1'b0;
      vec_inc    = 1'b0;
      res_clr    = 1'b0;

      case (state_q)
         HDR: begin
            if (accept) begin
               cal_num_d = s_tdata[CNT_W-1:0];
               err_len_d = 1'b0;
               beat_clr  = 1'b1;
               vec_clr   = 1'b1;
               res_clr   = 1'b1;
               state_d   = WGT;
            end
         end
         WGT: begin
            if (accept) begin
               wgt_we_d   = 1'b1;
               wgt_idx_d  = beat_cnt;
               wgt_data_d = {{(TW-DATA_WIDTH){s_tdata[DATA_WIDTH-1]}}, s_tdata[DATA_WIDTH-1:0]};
               if (beat_tc) begin
                  beat_clr = 1'b1;
                  state_d  = MAT;
               end else begin
                  beat_inc = 1'b1;
               end
            end
         end
         MAT: begin
            if (accept) begin
               mat_we_d   = 1'b1;
               mat_row_d  = beat_cnt[1:0];
               mat_data_d = s_tdata;
               if (beat_tc)
                  state_d = VEC;
               else
                  beat_inc = 1'b1;
            end
         end
         VEC: begin
            if (accept) begin
               if (vec_tc)
                  state_d = (cal_num_q == '0) ? HDR : WAIT_RES;
               else
                  vec_inc = 1'b1;
            end
         end
         WAIT_RES: begin
            if (res_done || m_tlast)
               state_d = HDR;
         end
         default: state_d = HDR;
      endcase

      if (short_frame) begin
         state_d   = HDR;
         err_len_d = 1'b1;
         flush_d   = 1'b1;
         beat_clr  = 1'b1;
         vec_clr   = 1'b1;
         res_clr   = 1'b1;
      end
   end

   // State and registered outputs.
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         state_q    <= HDR;
         cal_num_q  <= '0;
         err_len_q  <= 1'b0;
         flush_q    <= 1'b0;
         wgt_we_q   <= 1'b0;
         wgt_idx_q  <= '0;
         wgt_data_q <= '0;
         mat_we_q   <= 1'b0;
         mat_row_q  <= '0;
         mat_data_q <= '0;
      end else begin
         state_q    <= state_d;
         cal_num_q  <= cal_num_d;
         err_len_q  <= err_len_d;
         flush_q    <= flush_d;
         wgt_we_q   <= wgt_we_d;
         wgt_idx_q  <= wgt_idx_d;
         wgt_data_q <= wgt_data_d;
         mat_we_q   <= mat_we_d;
         mat_row_q  <= mat_row_d;
         mat_data_q <= mat_data_d;
      end
   end

`ifdef HORNER_FRAME_STATS_EN
   logic        frame_done;
   logic [31:0] frame_cnt_q;
   logic [15:0] err_cnt_q;

   assign frame_done = (in_vec && accept && vec_tc && !short_frame && (cal_num_q == '0)) ||
                       ((state_q == WAIT_RES) && (res_done || m_tlast));

   // Completed and truncated frame counters, free-running with wrap.
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         if (frame_done)
            frame_cnt_q <= frame_cnt_q + 32'd1;
         if (short_frame)
            err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_horner_frame_ctrl.sv
// Self-checking bench for horner_frame_ctrl: randomized frames against a queue-based reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_horner_frame_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] s_tdata;
   logic        s_tvalid, s_tready, s_tlast;
   logic        wgt_we, mat_we, vec_valid, vec_ready, vec_last;
   logic [3:0]  wgt_idx;
   logic [1:0]  mat_row, vec_cls;
   logic [63:0] wgt_data, mat_data, vec_data;
   logic        res_valid, m_tlast, flush, busy, err_len;
   logic [15:0] cal_num;
`ifdef HORNER_FRAME_STATS_EN
   logic [31:0] frame_cnt;
   logic [15:0] err_cnt;
`endif

   int checks = 0;
   int failures = 0;
   int exp_frames = 0;
   int exp_errs = 0;

   // expected and observed event streams
   logic [63:0] exp_widx[$], exp_wdat[$], exp_mrow[$], exp_mdat[$];
   logic [63:0] exp_vdat[$], exp_vcls[$], exp_vlast[$];
   logic [63:0] obs_widx[$], obs_wdat[$], obs_mrow[$], obs_mdat[$];
   logic [63:0] obs_vdat[$], obs_vcls[$], obs_vlast[$];
   int mt_cnt, mt_at, res_seen, flush_cnt, stall_cyc;

   always #5 clk = ~clk;

   horner_frame_ctrl dut (
      .s00_axis_aclk    (clk),
      .s00_axis_aresetn (rst_n),
      .s_tdata          (s_tdata),
      .s_tvalid         (s_tvalid),
      .s_tready         (s_tready),
      .s_tlast          (s_tlast),
      .wgt_we           (wgt_we),
      .wgt_idx          (wgt_idx),
      .wgt_data         (wgt_data),
      .mat_we           (mat_we),
      .mat_row          (mat_row),
      .mat_data         (mat_data),
      .vec_valid        (vec_valid),
      .vec_ready        (vec_ready),
      .vec_data         (vec_data),
      .vec_cls          (vec_cls),
      .vec_last         (vec_last),
      .res_valid        (res_valid),
      .m_tlast          (m_tlast),
      .flush            (flush),
      .busy             (busy),
      .err_len          (err_len),
`ifdef HORNER_FRAME_STATS_EN
      .frame_cnt        (frame_cnt),
      .err_cnt          (err_cnt),
`endif
      .cal_num          (cal_num)
   );

   // Passive recorder, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (wgt_we) begin obs_widx.push_back(64'(wgt_idx)); obs_wdat.push_back(wgt_data); end
         if (mat_we) begin obs_mrow.push_back(64'(mat_row)); obs_mdat.push_back(mat_data); end
         if (vec_valid && vec_ready) begin
            obs_vdat.push_back(vec_data);
            obs_vcls.push_back(64'(vec_cls));
            obs_vlast.push_back(64'(vec_last));
         end
         if (res_valid) res_seen++;
         if (m_tlast) begin mt_cnt++; mt_at = res_seen; end
         if (flush) flush_cnt++;
         if (s_tvalid && !s_tready) stall_cyc++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] sext16(input logic [15:0] x);
      return 64'($signed(x));
   endfunction

   task automatic clear_obs();
      obs_widx.delete(); obs_wdat.delete(); obs_mrow.delete(); obs_mdat.delete();
      obs_vdat.delete(); obs_vcls.delete(); obs_vlast.delete();
      exp_widx.delete(); exp_wdat.delete(); exp_mrow.delete(); exp_mdat.delete();
      exp_vdat.delete(); exp_vcls.delete(); exp_vlast.delete();
      mt_cnt = 0; mt_at = 0; res_seen = 0; flush_cnt = 0; stall_cyc = 0;
   endtask

   // One beat with bounded wait for acceptance; r pulses res_valid on the first cycle.
   task automatic send_beat(input logic [63:0] d, input logic l, input logic r);
      int  n;
      logic acc;
      s_tdata = d; s_tlast = l; s_tvalid = 1'b1; res_valid = r;
      n = 0; acc = 1'b0;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = s_tready;
         @(posedge clk); #1;
         n++;
         res_valid = 1'b0;
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      chk("beat_accepted", 64'(acc), 64'd1);
   endtask

   task automatic pulse_results(input int c);
      for (int k = 0; k < c; k++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         res_valid = 1'b1;
         @(posedge clk); #1;
         res_valid = 1'b0;
      end
   endtask

   // Full frame: header c, weights, rows, 11 + c vectors. err_at truncates at that vector.
   task automatic send_frame(input int c, input int err_at, input int stall_at,
                             input bit res_in_vec, input bit hdr_last, input bit final_last);
      logic [63:0] d;
      int total, cls;
      d = {$urandom, $urandom};
      d[15:0] = c[15:0];
      send_beat(d, hdr_last, 1'b0);
      chk("cal_num", 64'(cal_num), 64'(c));
      for (int i = 0; i < 16; i++) begin
         d = {$urandom, $urandom};
         exp_widx.push_back(64'(i));
         exp_wdat.push_back(sext16(d[15:0]));
         send_beat(d, 1'b0, 1'b0);
      end
      for (int r = 0; r < 3; r++) begin
         d = {$urandom, $urandom};
         exp_mrow.push_back(64'(r));
         exp_mdat.push_back(d);
         send_beat(d, 1'b0, 1'b0);
      end
      total = 11 + c;
      for (int v = 0; v < total; v++) begin
         d = {$urandom, $urandom};
         cls = (v < 3) ? 0 : (v < 9) ? 1 : (v < 11) ? 2 : 3;
         exp_vdat.push_back(d);
         exp_vcls.push_back(64'(cls));
         exp_vlast.push_back(64'(v == total - 1));
         if (v == err_at) begin
            send_beat(d, 1'b1, 1'b0);
            exp_errs++;
            return;
         end
         if (v == stall_at) begin
            vec_ready = 1'b0;
            s_tdata = d; s_tlast = 1'b0; s_tvalid = 1'b1;
            stall_cyc = 0;
            repeat (5) begin @(posedge clk); #1; end
            vec_ready = 1'b1;
         end
         send_beat(d, (v == total - 1) && final_last, res_in_vec && (v >= 11));
      end
      if (!res_in_vec) pulse_results(c);
      exp_frames++;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 200) begin @(posedge clk); #1; n++; end
      chk(tag, 64'(busy), 64'd0);
   endtask

   task automatic check_frame(input string p);
      chk({p, "_nwgt"}, 64'(obs_widx.size()), 64'(exp_widx.size()));
      for (int i = 0; i < obs_widx.size() && i < exp_widx.size(); i++) begin
         chk($sformatf("%s_widx%0d", p, i), obs_widx[i], exp_widx[i]);
         chk($sformatf("%s_wdat%0d", p, i), obs_wdat[i], exp_wdat[i]);
      end
      chk({p, "_nmat"}, 64'(obs_mrow.size()), 64'(exp_mrow.size()));
      for (int i = 0; i < obs_mrow.size() && i < exp_mrow.size(); i++) begin
         chk($sformatf("%s_mrow%0d", p, i), obs_mrow[i], exp_mrow[i]);
         chk($sformatf("%s_mdat%0d", p, i), obs_mdat[i], exp_mdat[i]);
      end
      chk({p, "_nvec"}, 64'(obs_vdat.size()), 64'(exp_vdat.size()));
      for (int i = 0; i < obs_vdat.size() && i < exp_vdat.size(); i++) begin
         chk($sformatf("%s_vdat%0d", p, i), obs_vdat[i], exp_vdat[i]);
         chk($sformatf("%s_vcls%0d", p, i), obs_vcls[i], exp_vcls[i]);
         chk($sformatf("%s_vlast%0d", p, i), obs_vlast[i], exp_vlast[i]);
      end
   endtask

   initial begin
      int c;
      bit rv;
      logic [63:0] d;
      rst_n = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
      vec_ready = 1'b1; res_valid = 1'b0;
      clear_obs();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tready", 64'(s_tready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_outs", {58'd0, wgt_we, mat_we, vec_valid, m_tlast, flush, err_len}, 64'd0);
      chk("rst_cal_num", 64'(cal_num), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // nominal frame
      clear_obs();
      send_frame(3, -1, -1, 1'b0, 1'b0, 1'b1);
      wait_idle("nom_idle");
      check_frame("nom");
      chk("nom_mtlast_cnt", 64'(mt_cnt), 64'd1);
      chk("nom_mtlast_at", 64'(mt_at), 64'd3);
      chk("nom_err_len", 64'(err_len), 64'd0);
      chk("nom_flush_cnt", 64'(flush_cnt), 64'd0);

      // datapath stall on second IFACE vector
      clear_obs();
      send_frame(2, -1, 4, 1'b0, 1'b0, 1'b1);
      wait_idle("stall_idle");
      check_frame("stall");
      chk("stall_cycles", 64'(stall_cyc), 64'd5);
      chk("stall_mtlast_cnt", 64'(mt_cnt), 64'd1);

      // short frame: s_tlast on vector 5
      clear_obs();
      send_frame(3, 4, -1, 1'b0, 1'b0, 1'b0);
      chk("short_flush_now", 64'(flush), 64'd1);
      chk("short_err_len", 64'(err_len), 64'd1);
      chk("short_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      chk("short_flush_after", 64'(flush), 64'd0);
      check_frame("short");
      chk("short_flush_cnt", 64'(flush_cnt), 64'd1);
      chk("short_mtlast_cnt", 64'(mt_cnt), 64'd0);

      // recovery frame, with s_tlast on the header (ignored)
      clear_obs();
      send_frame(1, -1, -1, 1'b0, 1'b1, 1'b1);
      wait_idle("recov_idle");
      check_frame("recov");
      chk("recov_err_len", 64'(err_len), 64'd0);
      chk("recov_mtlast_cnt", 64'(mt_cnt), 64'd1);

      // CAL_NUM = 0: straight back to HDR after the 11th vector
      clear_obs();
      send_frame(0, -1, -1, 1'b0, 1'b0, 1'b1);
      chk("zero_busy_now", 64'(busy), 64'd0);
      check_frame("zero");
      chk("zero_mtlast_cnt", 64'(mt_cnt), 64'd0);

      // async reset while at weight 7
      clear_obs();
      d = {$urandom, $urandom};
      d[15:0] = 16'd3;
      send_beat(d, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) send_beat({$urandom, $urandom}, 1'b0, 1'b0);
      chk("pre_rst_busy", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_tready", 64'(s_tready), 64'd1);
      chk("arst_outs", {58'd0, wgt_we, mat_we, vec_valid, m_tlast, flush, err_len}, 64'd0);
      chk("arst_cal_num", 64'(cal_num), 64'd0);
      chk("arst_wgt_idx", 64'(wgt_idx), 64'd0);
      exp_frames = 0; exp_errs = 0;
`ifdef HORNER_FRAME_STATS_EN
      chk("arst_frame_cnt", 64'(frame_cnt), 64'd0);
      chk("arst_err_cnt", 64'(err_cnt), 64'd0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      clear_obs();
      send_frame(3, -1, -1, 1'b0, 1'b0, 1'b1);
      wait_idle("post_rst_idle");
      check_frame("post_rst");
      chk("post_rst_mtlast_cnt", 64'(mt_cnt), 64'd1);

      // three back-to-back frames, results returned during VEC
      clear_obs();
      for (int f = 0; f < 3; f++) send_frame(int'($urandom_range(1, 4)), -1, -1, 1'b1, 1'b0, 1'b1);
      wait_idle("b2b_idle");
      check_frame("b2b");
      chk("b2b_mtlast_cnt", 64'(mt_cnt), 64'd3);
`ifdef HORNER_FRAME_STATS_EN
      chk("b2b_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
      chk("b2b_err_cnt", 64'(err_cnt), 64'(exp_errs));
`endif

      // randomized frames
      for (int f = 0; f < 4; f++) begin
         c  = int'($urandom_range(0, 5));
         rv = 1'($urandom_range(0, 1));
         clear_obs();
         send_frame(c, -1, -1, rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         wait_idle($sformatf("rnd%0d_idle", f));
         check_frame($sformatf("rnd%0d", f));
         chk($sformatf("rnd%0d_mtlast_cnt", f), 64'(mt_cnt), 64'(c > 0));
         if (c > 0) chk($sformatf("rnd%0d_mtlast_at", f), 64'(mt_at), 64'(c));
      end
`ifdef HORNER_FRAME_STATS_EN
      chk("end_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
      chk("end_err_cnt", 64'(err_cnt), 64'(exp_errs));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
